// File: rtl/vending_fsm_multi_if.sv
// rtl/vending_fsm_multi_if.sv - front-end/dispenser signal bundle for the multi-channel vending controller
interface vending_fsm_multi_if #(
  parameter int NUM_DRINKS = 4,
  parameter int CREDIT_W   = 8
);
  localparam int IDX_W = (NUM_DRINKS > 1) ? $clog2(NUM_DRINKS) : 1;

  // coin acceptor / selection panel side
  logic                  coin_valid;
  logic [CREDIT_W-1:0]   coin;
  logic                  sel_valid;
  logic [IDX_W-1:0]      sel_idx;
  logic                  cancel;

  // display / dispenser / change hopper side
  logic [CREDIT_W-1:0]   credit;
  logic [NUM_DRINKS-1:0] affordable;
  logic                  busy;
  logic                  coin_reject;
  logic                  sel_err;
  logic                  drink_valid;
  logic [IDX_W-1:0]      drink_idx;
  logic                  change_valid;
  logic [CREDIT_W-1:0]   change_amount;

  // front end that presents coins and selections and watches the results
  modport master (
    output coin_valid, coin, sel_valid, sel_idx, cancel,
    input  credit, affordable, busy, coin_reject, sel_err,
    input  drink_valid, drink_idx, change_valid, change_amount
  );

  // the vending controller itself
  modport slave (
    input  coin_valid, coin, sel_valid, sel_idx, cancel,
    output credit, affordable, busy, coin_reject, sel_err,
    output drink_valid, drink_idx, change_valid, change_amount
  );
endinterface

// File: rtl/vending_fsm_multi.sv
// rtl/vending_fsm_multi.sv - multi-channel vending controller; optional inactivity refund under VEND_TIMEOUT_EN
module vending_fsm_multi #(
  parameter int                               NUM_DRINKS  = 4,
  parameter int                               CREDIT_W    = 8,
  parameter logic [NUM_DRINKS*CREDIT_W-1:0]   PRICES      = {8'd25, 8'd20, 8'd15, 8'd10},
  parameter int                               MAX_CREDIT  = 100,
  parameter int                               TIMEOUT_CYC = 1000
) (
  input  logic               clk,
  input  logic               reset,
  vending_fsm_multi_if.slave bus
);
  localparam int IDX_W = (NUM_DRINKS > 1) ? $clog2(NUM_DRINKS) : 1;
  localparam logic [CREDIT_W:0] MAX_C = (CREDIT_W+1)'(MAX_CREDIT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CREDIT = 2'd1,
    S_VEND   = 2'd2,
    S_CHANGE = 2'd3
  } state_t;

  state_t state;

  logic [CREDIT_W:0]   coin_sum;
  logic                coin_ok;
  logic [CREDIT_W-1:0] sel_price;
  logic                sel_in_range;
  logic                sel_ok;
  logic [CREDIT_W-1:0] credit_after_sel;

`ifdef VEND_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYC);
  logic [TMO_W-1:0] tmo_cnt;
`endif

  // Bit i set when the given credit covers channel i's price.
  function automatic logic [NUM_DRINKS-1:0] afford_mask(input logic [CREDIT_W-1:0] c);
    logic [NUM_DRINKS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_DRINKS; i++) begin
      m[i] = (c >= PRICES[i*CREDIT_W +: CREDIT_W]);
    end
    return m;
  endfunction

  // Coin acceptance and price lookup; the sum is one bit wider so an overflow cannot wrap past the ceiling.
  always_comb begin
    coin_sum     = {1'b0, bus.credit} + {1'b0, bus.coin};
    coin_ok      = bus.coin_valid && (coin_sum <= MAX_C);
    sel_price    = '0;
    sel_in_range = 1'b0;
    for (int i = 0; i < NUM_DRINKS; i++) begin
      if (bus.sel_idx == IDX_W'(i)) begin
        sel_price    = PRICES[i*CREDIT_W +: CREDIT_W];
        sel_in_range = 1'b1;
      end
    end
    sel_ok           = sel_in_range && (sel_price <= bus.credit);
    credit_after_sel = bus.credit - sel_price;
  end

  // Main FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= S_IDLE;
      bus.credit        <= '0;
      bus.affordable    <= '0;
      bus.busy          <= 1'b0;
      bus.coin_reject   <= 1'b0;
      bus.sel_err       <= 1'b0;
      bus.drink_valid   <= 1'b0;
      bus.drink_idx     <= '0;
      bus.change_valid  <= 1'b0;
      bus.change_amount <= '0;
`ifdef VEND_TIMEOUT_EN
      tmo_cnt           <= '0;
`endif
    end else begin
      bus.coin_reject  <= 1'b0;
      bus.sel_err      <= 1'b0;
      bus.drink_valid  <= 1'b0;
      bus.change_valid <= 1'b0;

      case (state)
        S_IDLE, S_CREDIT: begin
          // cancel with no credit is meaningless, so it does not shadow the lower-priority inputs
          if (bus.cancel && state == S_CREDIT) begin
            state    <= S_CHANGE;
            bus.busy <= 1'b1;
            if (bus.coin_valid) bus.coin_reject <= 1'b1;
          end else if (bus.sel_valid) begin
            if (bus.coin_valid) bus.coin_reject <= 1'b1;
            if (sel_ok) begin
              state           <= S_VEND;
              bus.busy        <= 1'b1;
              bus.drink_valid <= 1'b1;
              bus.drink_idx   <= bus.sel_idx;
              bus.credit      <= credit_after_sel;
              bus.affordable  <= afford_mask(credit_after_sel);
            end else begin
              bus.sel_err <= 1'b1;
            end
          end else if (bus.coin_valid) begin
            if (coin_ok) begin
              bus.credit     <= coin_sum[CREDIT_W-1:0];
              bus.affordable <= afford_mask(coin_sum[CREDIT_W-1:0]);
              state          <= (coin_sum == '0) ? S_IDLE : S_CREDIT;
            end else begin
              bus.coin_reject <= 1'b1;
            end
          end
`ifdef VEND_TIMEOUT_EN
          // inactivity refund takes the same route as a cancel
          if (state == S_CREDIT && tmo_cnt == TMO_MAX &&
              !bus.cancel && !bus.sel_valid && !coin_ok) begin
            state    <= S_CHANGE;
            bus.busy <= 1'b1;
          end
`endif
        end

        S_VEND: begin
          // change goes out on entry to CHANGE so a vend finishes in three cycles
          state    <= S_CHANGE;
          bus.busy <= 1'b1;
          if (bus.credit != '0) begin
            bus.change_valid  <= 1'b1;
            bus.change_amount <= bus.credit;
          end
          if (bus.coin_valid) bus.coin_reject <= 1'b1;
          if (bus.sel_valid)  bus.sel_err     <= 1'b1;
        end

        S_CHANGE: begin
          // a cancel arrives here without a pulse issued yet, so CHANGE lasts one extra cycle for it
          if (bus.change_valid || bus.credit == '0) begin
            state          <= S_IDLE;
            bus.busy       <= 1'b0;
            bus.credit     <= '0;
            bus.affordable <= afford_mask('0);
          end else begin
            bus.change_valid  <= 1'b1;
            bus.change_amount <= bus.credit;
          end
          if (bus.coin_valid) bus.coin_reject <= 1'b1;
          if (bus.sel_valid)  bus.sel_err     <= 1'b1;
        end

        default: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
        end
      endcase

`ifdef VEND_TIMEOUT_EN
      // inactivity counter: only runs while holding credit, saturates at the limit
      if (state != S_CREDIT || bus.cancel || bus.sel_valid || coin_ok) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt != TMO_MAX) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
`endif
    end
  end
endmodule

// File: tb/tb_vending_fsm_multi.sv
// tb/tb_vending_fsm_multi.sv - scoreboard bench for vending_fsm_multi
module tb_vending_fsm_multi;
  localparam int ND = 4;
  localparam int CW = 8;
  // channel 0 = 10, 1 = 20, 2 = 15, 3 = 25
  localparam logic [ND*CW-1:0] PR = {8'd25, 8'd15, 8'd20, 8'd10};

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  ev_t q_drink[$];
  ev_t q_change[$];
  ev_t q_rej[$];
  ev_t q_serr[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vending_fsm_multi_if #(.NUM_DRINKS(ND), .CREDIT_W(CW)) ifc ();

  vending_fsm_multi #(
    .NUM_DRINKS(ND), .CREDIT_W(CW), .PRICES(PR),
    .MAX_CREDIT(100), .TIMEOUT_CYC(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  function automatic int price(input int i);
    logic [ND*CW-1:0] t;
    t = PR >> (i * CW);
    return int'(t[CW-1:0]);
  endfunction

  function automatic logic [ND-1:0] exp_aff(input int c);
    logic [ND-1:0] m;
    for (int i = 0; i < ND; i++) m[i] = (c >= price(i));
    return m;
  endfunction

  // Pulse monitor: each output pulse must match the head of its expectation queue.
  always @(negedge clk) begin
    ev_t e;
    if (reset) begin
      if (ifc.drink_valid) begin
        checks++;
        if (q_drink.size() == 0) begin
          errors++; $display("FAIL drink_unexpected cyc=%0d idx=%0d", cyc, ifc.drink_idx);
        end else begin
          e = q_drink.pop_front();
          if (e.cyc !== cyc || e.val !== int'(ifc.drink_idx)) begin
            errors++; $display("FAIL drink got cyc=%0d idx=%0d want cyc=%0d idx=%0d", cyc, ifc.drink_idx, e.cyc, e.val);
          end
        end
      end
      if (ifc.change_valid) begin
        checks++;
        if (q_change.size() == 0) begin
          errors++; $display("FAIL change_unexpected cyc=%0d amount=%0d", cyc, ifc.change_amount);
        end else begin
          e = q_change.pop_front();
          if ((e.cyc >= 0 && e.cyc !== cyc) || e.val !== int'(ifc.change_amount)) begin
            errors++; $display("FAIL change got cyc=%0d amount=%0d want cyc=%0d amount=%0d", cyc, ifc.change_amount, e.cyc, e.val);
          end
        end
      end
      if (ifc.coin_reject) begin
        checks++;
        if (q_rej.size() == 0) begin
          errors++; $display("FAIL coin_reject_unexpected cyc=%0d", cyc);
        end else begin
          e = q_rej.pop_front();
          if (e.cyc !== cyc) begin
            errors++; $display("FAIL coin_reject got cyc=%0d want cyc=%0d", cyc, e.cyc);
          end
        end
      end
      if (ifc.sel_err) begin
        checks++;
        if (q_serr.size() == 0) begin
          errors++; $display("FAIL sel_err_unexpected cyc=%0d", cyc);
        end else begin
          e = q_serr.pop_front();
          if (e.cyc !== cyc) begin
            errors++; $display("FAIL sel_err got cyc=%0d want cyc=%0d", cyc, e.cyc);
          end
        end
      end
    end
  end

  task automatic step(input logic cv, input int cval, input logic sv, input int sidx, input logic cn);
    logic [31:0] cv32;
    logic [31:0] si32;
    cv32 = cval;
    si32 = sidx;
    ifc.coin_valid = cv;
    ifc.coin       = cv32[CW-1:0];
    ifc.sel_valid  = sv;
    ifc.sel_idx    = si32[1:0];
    ifc.cancel     = cn;
    @(posedge clk); #1;
    ifc.coin_valid = 1'b0;
    ifc.coin       = '0;
    ifc.sel_valid  = 1'b0;
    ifc.sel_idx    = '0;
    ifc.cancel     = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    checks++; if (ifc.credit !== 8'd0) begin errors++; $display("FAIL rst_credit got %0d want 0", ifc.credit); end
    checks++; if (ifc.affordable !== 4'd0) begin errors++; $display("FAIL rst_afford got %b want 0000", ifc.affordable); end
    checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", ifc.busy); end
    checks++; if (ifc.drink_idx !== 2'd0 || ifc.change_amount !== 8'd0) begin
      errors++; $display("FAIL rst_idx_amt got %0d/%0d want 0/0", ifc.drink_idx, ifc.change_amount);
    end
    step(1'b1, 10, 1'b0, 0, 1'b0);
    step(1'b1, 20, 1'b0, 0, 1'b0);
    checks++; if (ifc.credit !== 8'd30) begin errors++; $display("FAIL pre_rst_credit got %0d want 30", ifc.credit); end
    #2 reset = 1'b0;
    #1;
    checks++; if (ifc.credit !== 8'd0 || ifc.affordable !== 4'd0 || ifc.busy !== 1'b0) begin
      errors++; $display("FAIL async_rst got credit=%0d aff=%b busy=%b want 0", ifc.credit, ifc.affordable, ifc.busy);
    end
    idle(1);
    reset = 1'b1;
    idle(1);
    checks++; if (ifc.credit !== 8'd0 || ifc.busy !== 1'b0) begin
      errors++; $display("FAIL post_rst got credit=%0d busy=%b want 0/0", ifc.credit, ifc.busy);
    end
    step(1'b1, 5, 1'b0, 0, 1'b0);
    checks++; if (ifc.credit !== 8'd5 || ifc.affordable !== exp_aff(5)) begin
      errors++; $display("FAIL post_rst_coin got %0d/%b want 5/%b", ifc.credit, ifc.affordable, exp_aff(5));
    end
    q_change.push_back('{cyc + 2, 5});
    step(1'b0, 0, 1'b0, 0, 1'b1);
    idle(3);
  endtask

  task automatic test_sel_err;
    step(1'b1, 10, 1'b0, 0, 1'b0);
    step(1'b1, 5, 1'b0, 0, 1'b0);
    checks++; if (ifc.credit !== 8'd15) begin errors++; $display("FAIL sel_credit15 got %0d want 15", ifc.credit); end
    q_serr.push_back('{cyc + 1, 0});
    step(1'b0, 0, 1'b1, 1, 1'b0);
    checks++; if (ifc.credit !== 8'd15 || ifc.busy !== 1'b0) begin
      errors++; $display("FAIL sel_err_hold got %0d/%b want 15/0", ifc.credit, ifc.busy);
    end
    step(1'b1, 10, 1'b0, 0, 1'b0);
    checks++; if (ifc.credit !== 8'd25 || ifc.affordable !== exp_aff(25)) begin
      errors++; $display("FAIL sel_credit25 got %0d/%b want 25/%b", ifc.credit, ifc.affordable, exp_aff(25));
    end
    q_drink.push_back('{cyc + 1, 1});
    q_change.push_back('{cyc + 2, 5});
    step(1'b0, 0, 1'b1, 1, 1'b0);
    checks++; if (ifc.credit !== 8'd5 || ifc.busy !== 1'b1) begin
      errors++; $display("FAIL vend_state got %0d/%b want 5/1", ifc.credit, ifc.busy);
    end
    idle(1);
    checks++; if (ifc.busy !== 1'b1) begin errors++; $display("FAIL change_busy got %b want 1", ifc.busy); end
    idle(1);
    checks++; if (ifc.credit !== 8'd0 || ifc.busy !== 1'b0 || ifc.affordable !== exp_aff(0)) begin
      errors++; $display("FAIL vend_done got %0d/%b/%b want 0/0/%b", ifc.credit, ifc.busy, ifc.affordable, exp_aff(0));
    end
  endtask

  task automatic test_max_credit;
    step(1'b1, 50, 1'b0, 0, 1'b0);
    step(1'b1, 50, 1'b0, 0, 1'b0);
    checks++; if (ifc.credit !== 8'd100 || ifc.affordable !== 4'b1111) begin
      errors++; $display("FAIL max_credit got %0d/%b want 100/1111", ifc.credit, ifc.affordable);
    end
    q_rej.push_back('{cyc + 1, 0});
    step(1'b1, 5, 1'b0, 0, 1'b0);
    checks++; if (ifc.credit !== 8'd100) begin errors++; $display("FAIL over_max got %0d want 100", ifc.credit); end
    q_change.push_back('{cyc + 2, 100});
    step(1'b0, 0, 1'b0, 0, 1'b1);
    idle(3);
  endtask

  task automatic test_priority;
    step(1'b1, 25, 1'b0, 0, 1'b0);
    q_rej.push_back('{cyc + 1, 0});
    q_change.push_back('{cyc + 2, 25});
    step(1'b1, 10, 1'b1, 0, 1'b1);
    checks++; if (ifc.busy !== 1'b1 || ifc.credit !== 8'd25) begin
      errors++; $display("FAIL prio_state got busy=%b credit=%0d want 1/25", ifc.busy, ifc.credit);
    end
    idle(3);
    checks++; if (ifc.credit !== 8'd0) begin errors++; $display("FAIL prio_done got %0d want 0", ifc.credit); end
  endtask

  task automatic test_exact_price;
    step(1'b1, 10, 1'b0, 0, 1'b0);
    q_drink.push_back('{cyc + 1, 0});
    step(1'b0, 0, 1'b1, 0, 1'b0);
    checks++; if (ifc.credit !== 8'd0 || ifc.busy !== 1'b1) begin
      errors++; $display("FAIL exact_vend got %0d/%b want 0/1", ifc.credit, ifc.busy);
    end
    q_rej.push_back('{cyc + 1, 0});
    q_serr.push_back('{cyc + 1, 0});
    step(1'b1, 5, 1'b1, 0, 1'b0);
    checks++; if (ifc.busy !== 1'b1) begin errors++; $display("FAIL exact_change_busy got %b want 1", ifc.busy); end
    idle(1);
    checks++; if (ifc.busy !== 1'b0 || ifc.credit !== 8'd0) begin
      errors++; $display("FAIL exact_idle got busy=%b credit=%0d want 0/0", ifc.busy, ifc.credit);
    end
  endtask

  task automatic test_timeout;
    step(1'b1, 15, 1'b0, 0, 1'b0);
`ifdef VEND_TIMEOUT_EN
    q_change.push_back('{-1, 15});
    for (int i = 0; i < 30 && q_change.size() != 0; i++) idle(1);
    checks++; if (q_change.size() !== 0) begin errors++; $display("FAIL timeout_refund got none want amount=15"); end
    idle(2);
    checks++; if (ifc.credit !== 8'd0 || ifc.busy !== 1'b0) begin
      errors++; $display("FAIL timeout_done got %0d/%b want 0/0", ifc.credit, ifc.busy);
    end
`else
    idle(20);
    checks++; if (ifc.credit !== 8'd15 || ifc.busy !== 1'b0) begin
      errors++; $display("FAIL hold_credit got %0d/%b want 15/0", ifc.credit, ifc.busy);
    end
    q_change.push_back('{cyc + 2, 15});
    step(1'b0, 0, 1'b0, 0, 1'b1);
    idle(3);
`endif
  endtask

  task automatic test_drain;
    idle(2);
    checks++; if (q_drink.size() + q_change.size() + q_rej.size() + q_serr.size() !== 0) begin
      errors++; $display("FAIL pending_events got %0d/%0d/%0d/%0d want 0", q_drink.size(), q_change.size(), q_rej.size(), q_serr.size());
    end
  endtask

  initial begin
    ifc.coin_valid = 1'b0;
    ifc.coin       = '0;
    ifc.sel_valid  = 1'b0;
    ifc.sel_idx    = '0;
    ifc.cancel     = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(1);
    test_reset;
    test_sel_err;
    test_max_credit;
    test_priority;
    test_exact_price;
    test_timeout;
    test_drain;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
